// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, field widths, ACK levels.
// Imported by both the target and the controller side.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        WR_PTR,
        ACK_PTR,
        WR_DATA,
        ACK_DATA,
        RD_LOAD,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_if.sv
// Pad-side and register-file-side signals of the I2C target.
// slave = the target itself, master = pads plus register file.
interface i2c_target_if;
    import i2c_pkg::*;

    logic                  scl_i;
    logic                  sda_i;
    logic                  sda_oe;
    logic [I2C_BYTE_W-1:0] reg_addr;
    logic [I2C_BYTE_W-1:0] reg_wdata;
    logic [I2C_BYTE_W-1:0] reg_rdata;
    logic                  reg_we;
    logic                  reg_re;
    logic                  busy;

    modport slave (
        input  scl_i, sda_i, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output scl_i, sda_i, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers on SCL/SDA plus a registered edge stage that
// yields SCL edges and START/STOP conditions.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_last_q;
    logic       sda_last_q;
    logic       scl_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_last_q <= 1'b1;
            sda_last_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_last_q <= scl_sync_q[1];
            sda_last_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda       = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_last_q;
    assign scl_fall  = ~scl_s & scl_last_q;
    // SCL must be high in both samples so an SCL edge never aliases.
    assign start_det = scl_s & scl_last_q & sda_last_q & ~sda;
    assign stop_det  = scl_s & scl_last_q & ~sda_last_q & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address and an auto-incrementing 8-bit
// register pointer; no clock stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus
);

    logic scl_rise, scl_fall, start_det, stop_det, sda;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda       (sda)
    );

    i2c_tgt_state_t        state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic [1:0]            ld_cnt_q, ld_cnt_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] addr_q, addr_d;
    logic [I2C_BYTE_W-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  busy_q, busy_d;

    logic [I2C_BYTE_W-1:0] rx_byte;
    logic                  last_bit;
    logic                  addr_hit;

    assign rx_byte  = {shift_q[I2C_BYTE_W-2:0], sda};
    assign last_bit = (bit_cnt_q == 3'd7);
    assign addr_hit = (rx_byte[I2C_BYTE_W-1:1] == TARGET_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            ld_cnt_q  <= '0;
            sda_oe_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            ld_cnt_q  <= ld_cnt_d;
            sda_oe_q  <= sda_oe_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else begin
            unique case (state_q)
                ADDR: if (scl_rise && last_bit)
                    state_d = addr_hit ? ACK_ADDR : WAIT_STOP;
                ACK_ADDR: begin
                    if (scl_fall && sda_oe_q && !rw_q)
                        state_d = WR_PTR;
                    else if (scl_rise && sda_oe_q && rw_q)
                        state_d = RD_LOAD;
                end
                WR_PTR: if (scl_rise && last_bit)
                    state_d = ACK_PTR;
                ACK_PTR: if (scl_fall && sda_oe_q)
                    state_d = WR_DATA;
                WR_DATA: if (scl_rise && last_bit)
                    state_d = ACK_DATA;
                ACK_DATA: if (scl_fall && sda_oe_q)
                    state_d = WR_DATA;
                RD_LOAD: if (ld_cnt_q == 2'd2)
                    state_d = RD_DATA;
                RD_DATA: if (scl_rise && last_bit)
                    state_d = RD_ACK;
                RD_ACK: if (scl_rise)
                    state_d = (sda == I2C_ACK) ? RD_LOAD : WAIT_STOP;
                default: ;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        ld_cnt_d  = '0;
        sda_oe_d  = sda_oe_q;
        addr_d    = addr_q + {{(I2C_BYTE_W-1){1'b0}}, we_q};
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        busy_d    = busy_q;
        if (stop_det) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ADDR, WR_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (state_q == ADDR) begin
                                rw_d   = sda;
                                busy_d = addr_hit;
                            end else if (state_q == WR_PTR) begin
                                addr_d = rx_byte;
                            end else begin
                                we_d    = 1'b1;
                                wdata_d = rx_byte;
                            end
                        end
                    end
                end
                // first fall drives the ACK, the next one releases it
                ACK_ADDR, ACK_PTR, ACK_DATA: begin
                    if (scl_fall)
                        sda_oe_d = ~sda_oe_q;
                end
                RD_LOAD: begin
                    ld_cnt_d = ld_cnt_q + 2'd1;
                    re_d     = (ld_cnt_q == 2'd0);
                    if (ld_cnt_q == 2'd2) begin
                        shift_d   = bus.reg_rdata;
                        bit_cnt_d = '0;
                    end
                end
                RD_DATA: begin
                    if (scl_fall)
                        sda_oe_d = ~shift_q[I2C_BYTE_W-1];
                    if (scl_rise) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_fall)
                        sda_oe_d = 1'b0;
                    if (scl_rise && sda == I2C_ACK)
                        addr_d = addr_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = we_q;
    assign bus.reg_re    = re_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, register-file model and
// strobe scoreboard.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [15:0] wr_q[$];
    logic [7:0]  ra_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  mem[256];
    logic [15:0] exp_w;
    logic [7:0]  exp_a;

    i2c_target_if bus();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_target #(.TARGET_ADDR(7'h42)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];

    always @(negedge clk) begin
        if (!rst && bus.reg_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL unexp_we: got %h/%h want none",
                         bus.reg_addr, bus.reg_wdata);
            end else begin
                exp_w = wr_q.pop_front();
                if ({bus.reg_addr, bus.reg_wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL we_addr_data: got %h%h want %h",
                             bus.reg_addr, bus.reg_wdata, exp_w);
                end
            end
        end
        if (!rst && bus.reg_re) begin
            checks++;
            if (ra_q.size() == 0) begin
                failures++;
                $display("FAIL unexp_re: got %h want none", bus.reg_addr);
            end else begin
                exp_a = ra_q.pop_front();
                if (bus.reg_addr !== exp_a) begin
                    failures++;
                    $display("FAIL re_addr: got %h want %h",
                             bus.reg_addr, exp_a);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic wbit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = bus.sda_i; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(5);
        @(negedge clk);
        checks++;
        if ({bus.sda_oe, bus.reg_we, bus.reg_re, bus.busy,
             bus.reg_addr, bus.reg_wdata} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outs: got %b%b%b%b %h %h want 0",
                     bus.sda_oe, bus.reg_we, bus.reg_re, bus.busy,
                     bus.reg_addr, bus.reg_wdata);
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_write;
        logic ack;
        wr_q.push_back({8'h10, 8'hA5});
        wr_q.push_back({8'h11, 8'h5A});
        i2c_start();
        wbyte(8'h84, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL wr_addr_ack: got %b want %b", ack, I2C_ACK);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_busy: got %b want 1", bus.busy);
        end
        wbyte(8'h10, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL wr_ptr_ack: got %b want %b", ack, I2C_ACK);
        end
        wbyte(8'hA5, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL wr_d0_ack: got %b want %b", ack, I2C_ACK);
        end
        wbyte(8'h5A, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL wr_d1_ack: got %b want %b", ack, I2C_ACK);
        end
        i2c_stop();
        tick(5);
        checks++;
        if ({bus.busy, bus.sda_oe, bus.reg_addr} !== {2'b00, 8'h12}) begin
            failures++;
            $display("FAIL wr_end: got %b%b %h want 00 12",
                     bus.busy, bus.sda_oe, bus.reg_addr);
        end
        checks++;
        if (wr_q.size() != 0) begin
            failures++;
            $display("FAIL wr_pending: got %0d want 0", wr_q.size());
        end
    endtask

    task automatic test_random_read;
        logic ack;
        logic [7:0] d;
        logic [7:0] e;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3;
        ra_q.push_back(8'h20);
        ra_q.push_back(8'h21);
        rd_q.push_back(mem[8'h20]);
        rd_q.push_back(mem[8'h21]);
        i2c_start();
        wbyte(8'h84, ack);
        wbyte(8'h20, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL rd_ptr_ack: got %b want %b", ack, I2C_ACK);
        end
        i2c_start();
        wbyte(8'h85, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL rd_addr_ack: got %b want %b", ack, I2C_ACK);
        end
        rbyte(d, I2C_ACK);
        e = rd_q.pop_front();
        checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL rd_byte0: got %h want %h", d, e);
        end
        rbyte(d, I2C_NACK);
        e = rd_q.pop_front();
        checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL rd_byte1: got %h want %h", d, e);
        end
        checks++;
        if (bus.sda_oe !== 1'b0) begin
            failures++;
            $display("FAIL rd_release: got %b want 0", bus.sda_oe);
        end
        i2c_stop();
        tick(5);
        checks++;
        if ({ra_q.size() == 0, bus.reg_addr} !== {1'b1, 8'h21}) begin
            failures++;
            $display("FAIL rd_end: got %0d %h want 0 21",
                     ra_q.size(), bus.reg_addr);
        end
    endtask

    task automatic test_wrong_addr;
        logic ack;
        i2c_start();
        wbyte(8'h86, ack);
        checks++;
        if (ack !== I2C_NACK) begin
            failures++;
            $display("FAIL wa_nack: got %b want %b", ack, I2C_NACK);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL wa_busy: got %b want 0", bus.busy);
        end
        wbyte(8'h99, ack);
        checks++;
        if (ack !== I2C_NACK) begin
            failures++;
            $display("FAIL wa_ignore: got %b want %b", ack, I2C_NACK);
        end
        i2c_stop();
        i2c_start();
        wbyte(8'h84, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL wa_next_ack: got %b want %b", ack, I2C_ACK);
        end
        i2c_stop();
        tick(5);
    endtask

    task automatic test_wrap_abort;
        logic ack;
        wr_q.push_back({8'hFF, 8'h11});
        wr_q.push_back({8'h00, 8'h22});
        i2c_start();
        wbyte(8'h84, ack);
        wbyte(8'hFF, ack);
        wbyte(8'h11, ack);
        wbyte(8'h22, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL wrap_ack: got %b want %b", ack, I2C_ACK);
        end
        for (int i = 0; i < 4; i++) wbit(1'b1);
        i2c_stop();
        tick(5);
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL abort_state: got %0d want %0d",
                     dut.state_q, IDLE);
        end
        checks++;
        if ({wr_q.size() == 0, bus.busy, bus.reg_addr} !==
            {2'b10, 8'h01}) begin
            failures++;
            $display("FAIL wrap_end: got %0d %b %h want 0 0 01",
                     wr_q.size(), bus.busy, bus.reg_addr);
        end
    endtask

    task automatic test_reset_mid_read;
        logic ack;
        mem[8'h01] = 8'h00;
        ra_q.push_back(8'h01);
        i2c_start();
        wbyte(8'h85, ack);
        checks++;
        if (bus.sda_oe !== 1'b1) begin
            failures++;
            $display("FAIL rmr_drive: got %b want 1", bus.sda_oe);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.sda_oe, bus.reg_we, bus.reg_re, bus.busy,
             bus.reg_addr, bus.reg_wdata} !== 20'h0) begin
            failures++;
            $display("FAIL rmr_outs: got %b%b%b%b %h %h want 0",
                     bus.sda_oe, bus.reg_we, bus.reg_re, bus.busy,
                     bus.reg_addr, bus.reg_wdata);
        end
        tick(3);
        @(negedge clk);
        rst = 1'b0;
        tick(4);
        sda_m = 1'b1;
        scl_m = 1'b1;
        tick(Q);
        wr_q.push_back({8'h30, 8'h77});
        i2c_start();
        wbyte(8'h84, ack);
        wbyte(8'h30, ack);
        wbyte(8'h77, ack);
        checks++;
        if (ack !== I2C_ACK) begin
            failures++;
            $display("FAIL rmr_wr_ack: got %b want %b", ack, I2C_ACK);
        end
        i2c_stop();
        tick(5);
        checks++;
        if ({wr_q.size() == 0, ra_q.size() == 0, bus.reg_addr} !==
            {2'b11, 8'h31}) begin
            failures++;
            $display("FAIL rmr_end: got %0d %0d %h want 0 0 31",
                     wr_q.size(), ra_q.size(), bus.reg_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        test_reset();
        test_write();
        test_random_read();
        test_wrong_addr();
        test_wrap_abort();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for 7-bit addressing, the far end of the bus driven by the team's I2C controller (`i2c_top`). Oversamples SCL/SDA on the system clock, detects START/STOP, and matches its own address. It exposes an 8-bit register-pointer interface: the first written byte sets the pointer, and later bytes write or read registers with auto-increment. It sits between the open-drain pad buffers and a local register file; clock stretching is not supported.

## Interface
- `TARGET_ADDR`, default 7'h42: 7-bit bus address this target answers to.
- `clk`  in  1  system clock, 50 MHz nominal; must be ≥ 20× SCL frequency.
- `rst`  in  1  reset; synchronous, active-high.
- `scl_i`  in  1  raw SCL pad input (asynchronous).
- `sda_i`  in  1  raw SDA pad input (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. The pad ties the driven value to 0.
- `reg_addr`  out  8  current register pointer.
- `reg_wdata`  out  8  write data; valid while `reg_we`=1.
- `reg_we`  out  1  1-cycle write strobe.
- `reg_re`  out  1  1-cycle read request at `reg_addr`.
- `reg_rdata`  in  8  read data, valid exactly 1 cycle after `reg_re`.
- `busy`  out  1  high from an address-matched START until STOP.

## Operation
- Front end: 2-FF synchronizer on both lines, then registered edge detect.
- START = SDA falling while SCL high. STOP = SDA rising while SCL high.
- Bits are sampled on detected SCL rising edges. `sda_oe` changes only on detected SCL falling edges, or on STOP/START/reset.
- States: IDLE, ADDR, ACK_ADDR, WR_PTR, ACK_PTR, WR_DATA, ACK_DATA, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE→ADDR on START. ADDR shifts 8 bits MSB-first (7 address bits + R/W).
- Address match: ACK_ADDR drives low for one SCL period, then goes to WR_PTR if R/W=0, or to RD_LOAD if R/W=1.
- Address mismatch: NACK by keeping SDA released, then WAIT_STOP.
- WR_PTR: 8 bits → `reg_addr`, then ACK_PTR → WR_DATA.
- WR_DATA: after 8 bits, pulse `reg_we` with `reg_wdata`, then ACK_DATA → WR_DATA. The pointer increments the cycle after `reg_we`.
- RD_LOAD: pulse `reg_re`, latch `reg_rdata` into the shift register on the next cycle, then RD_DATA.
- RD_DATA: drive the 8 bits MSB-first as `sda_oe = ~bit`. Then RD_ACK releases SDA and samples the controller's ACK.
  - ACK (0): increment the pointer, then RD_LOAD.
  - NACK (1): WAIT_STOP.
- Pointer wraps 8'hFF→8'h00.
- STOP from any state → IDLE, with `sda_oe`=0 and `busy`=0. A partial byte is discarded and no `reg_we` is issued.
- START from any non-IDLE state (repeated START) → ADDR. The pointer is retained, so a write-pointer-then-repeated-START read works.

## Timing
- Reset values:
  - outputs: `sda_oe`=0, `reg_we`=0, `reg_re`=0, `reg_addr`=8'h00, `reg_wdata`=8'h00, `busy`=0;
  - state: IDLE; synchronizer stages: 1.
- Pad-to-decision latency is 3 clk (2 sync + 1 edge register).
- `reg_we` asserts 1 clk after the 8th-bit SCL rise is detected.
- `reg_re` asserts 1 clk after entering RD_LOAD. Data is latched 1 clk later, well before the next SCL fall.
- ACK drive timing: asserted at the SCL fall after the 8th bit, released at the following SCL fall.
- START/STOP detection takes priority over a simultaneous SCL edge.
- `rst` mid-transaction releases SDA on the next clk. The block then ignores the bus until the next START.

## Structure
- Package `i2c_pkg`:
  - the state enum `i2c_tgt_state_t`;
  - `I2C_ADDR_W`=7;
  - `I2C_BYTE_W`=8;
  - the ACK/NACK constants. These are shared with the controller.
- Sub-module `i2c_line_sync`: synchronizers plus edge detect. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, and the synchronized `sda`.
- `i2c_target` contains the FSM, bit counter (0–7), shift register and pointer.

## Test plan
- Write: START, 0x84 (0x42,W), 0x10, 0xA5, 0x5A, STOP → three ACKs plus a data ACK. `reg_we` fires twice, with addr 0x10/data 0xA5 then addr 0x11/data 0x5A.
- Random read: START, 0x84, 0x20, repeated START, 0x85, model returns 0x3C then 0xC3, controller ACK then NACK, STOP.
  - Bus sees 0x3C, 0xC3.
  - `reg_re` fires at 0x20 and 0x21.
  - SDA is released after the NACK.
- Wrong address: START, 0x86 → SDA stays released at the ACK bit, no strobes, `busy`=0. The next valid START at 0x84 is ACKed.
- Wrap and abort:
  - Pointer 0xFF, write 2 bytes → writes to 0xFF then 0x00.
  - STOP after 4 bits of a third byte → no third `reg_we`, state IDLE.
- Reset mid-read: assert `rst` while `sda_oe`=1 → `sda_oe`=0 on the next clk, all outputs at reset values. A following write transaction completes normally.
